// File: rtl/nlfsr_pkg.sv
// Shared definitions for the NLFSR feedback search:
// FSM encoding, default watchdog limit, saturating increment.
package nlfsr_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_CLR      = 3'd1;
    localparam state_t S_WAIT_SEL = 3'd2;
    localparam state_t S_RUN      = 3'd3;
    localparam state_t S_REPORT   = 3'd4;
    localparam state_t S_NEXT     = 3'd5;
    localparam state_t S_DONE     = 3'd6;

    // A full period is 2^size-1 steps; leave a small margin.
    function automatic int unsigned default_timeout(input int unsigned size);
        return (32'd1 << size) + 32'd8;
    endfunction

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] lim;
        lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/nlfsr_search_ctrl_if.sv
// Result port of the NLFSR search sequencer.
// Valid/ready transfer of full-period candidate indices.
interface nlfsr_search_ctrl_if #(
    parameter int unsigned CAND_W = 16
);
    logic              hit_valid;
    logic [CAND_W-1:0] hit_idx;
    logic              hit_ready;

    modport master (
        output hit_valid,
        output hit_idx,
        input  hit_ready
    );

    modport slave (
        input  hit_valid,
        input  hit_idx,
        output hit_ready
    );
endinterface

// File: rtl/nlfsr_watchdog.sv
// Clearable, enabled, saturating cycle counter with a
// terminal-count flag at LIMIT-1.
module nlfsr_watchdog
    import nlfsr_pkg::*;
#(
    parameter int unsigned W     = 18,
    parameter int unsigned LIMIT = 65544
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= W'(sat_inc(32'(cnt), W));
        end
    end

    assign tc = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/nlfsr_search_ctrl.sv
// Sequencer for the exhaustive NLFSR feedback search:
// load candidate, reset/run NLFSR, collect verdict, report hits.
module nlfsr_search_ctrl
    import nlfsr_pkg::*;
#(
    parameter int unsigned SIZE    = 16,
    parameter int unsigned CAND_W  = 16,
    parameter int unsigned TIMEOUT = default_timeout(SIZE)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic              abort,
    input  logic [CAND_W-1:0] cand_first,
    input  logic [CAND_W-1:0] cand_last,
    output logic              sel_load,
    output logic [CAND_W-1:0] cand_idx,
    input  logic              sel_done,
    output logic              lfsr_res,
    output logic              lfsr_ena,
    input  logic              lfsr_found,
    input  logic              lfsr_failure,
    nlfsr_search_ctrl_if.master hit,
    output logic              busy,
    output logic              done,
    output logic [CAND_W-1:0] hit_count,
    output logic [CAND_W-1:0] tmo_count
);

    localparam int unsigned WD_W = SIZE + 2;

    state_t            state;
    logic [CAND_W-1:0] last_q;
    logic              hit_valid_q;
    logic [CAND_W-1:0] hit_idx_q;
    logic              wd_clr;
    logic              wd_en;
    logic              wd_tc;

    assign hit.hit_valid = hit_valid_q;
    assign hit.hit_idx   = hit_idx_q;

    // Watchdog restarts on every entry to RUN.
    assign wd_clr = (state == S_WAIT_SEL) && sel_done;
    assign wd_en  = (state == S_RUN);

    nlfsr_watchdog #(
        .W     (WD_W),
        .LIMIT (TIMEOUT)
    ) u_wd (
        .clk (clk),
        .res (res),
        .clr (wd_clr),
        .en  (wd_en),
        .tc  (wd_tc)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state       <= S_IDLE;
            last_q      <= '0;
            cand_idx    <= '0;
            sel_load    <= 1'b0;
            lfsr_res    <= 1'b0;
            lfsr_ena    <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_idx_q   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit_count   <= '0;
            tmo_count   <= '0;
        end else begin
            sel_load <= 1'b0;
            lfsr_res <= 1'b0;
            done     <= 1'b0;
            if (abort && state != S_IDLE) begin
                state       <= S_IDLE;
                busy        <= 1'b0;
                lfsr_ena    <= 1'b0;
                hit_valid_q <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            last_q    <= cand_last;
                            cand_idx  <= cand_first;
                            hit_count <= '0;
                            tmo_count <= '0;
                            sel_load  <= 1'b1;
                            lfsr_res  <= 1'b1;
                            lfsr_ena  <= 1'b0;
                            busy      <= 1'b1;
                            state     <= S_CLR;
                        end
                    end
                    S_CLR: begin
                        state <= S_WAIT_SEL;
                    end
                    S_WAIT_SEL: begin
                        if (sel_done) begin
                            lfsr_ena <= 1'b1;
                            state    <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (lfsr_failure) begin
                            lfsr_ena <= 1'b0;
                            state    <= S_NEXT;
                        end else if (wd_tc) begin
                            tmo_count <= CAND_W'(sat_inc(32'(tmo_count), CAND_W));
                            lfsr_ena  <= 1'b0;
                            state     <= S_NEXT;
                        end else if (lfsr_found) begin
                            hit_count   <= CAND_W'(sat_inc(32'(hit_count), CAND_W));
                            hit_idx_q   <= cand_idx;
                            hit_valid_q <= 1'b1;
                            lfsr_ena    <= 1'b0;
                            state       <= S_REPORT;
                        end
                    end
                    S_REPORT: begin
                        if (hit.hit_ready) begin
                            hit_valid_q <= 1'b0;
                            state       <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (cand_idx == last_q) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cand_idx <= cand_idx + 1'b1;
                            sel_load <= 1'b1;
                            lfsr_res <= 1'b1;
                            state    <= S_CLR;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nlfsr_search_ctrl.sv
// Bench for nlfsr_search_ctrl: behavioural selector/NLFSR model,
// table of search ranges plus stall, abort and reset sequences.
module tb_nlfsr_search_ctrl;

    localparam int SIZE   = 4;
    localparam int CAND_W = 16;
    localparam int TMO    = 24;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cand_first = '0;
    logic [15:0] cand_last = '0;
    logic        sel_load, sel_done, lfsr_res, lfsr_ena;
    logic        lfsr_found, lfsr_failure, busy, done;
    logic [15:0] cand_idx, hit_count, tmo_count;

    nlfsr_search_ctrl_if #(.CAND_W(CAND_W)) hit_bus ();

    nlfsr_search_ctrl #(
        .SIZE   (SIZE),
        .CAND_W (CAND_W)
    ) dut (
        .clk          (clk),
        .res          (res),
        .start        (start),
        .abort        (abort),
        .cand_first   (cand_first),
        .cand_last    (cand_last),
        .sel_load     (sel_load),
        .cand_idx     (cand_idx),
        .sel_done     (sel_done),
        .lfsr_res     (lfsr_res),
        .lfsr_ena     (lfsr_ena),
        .lfsr_found   (lfsr_found),
        .lfsr_failure (lfsr_failure),
        .hit          (hit_bus),
        .busy         (busy),
        .done         (done),
        .hit_count    (hit_count),
        .tmo_count    (tmo_count)
    );

    always #5 clk = ~clk;

    // Selector + NLFSR model: found after 15 steps, failure after 5.
    bit          mute = 1'b0;
    bit          both = 1'b0;
    logic [15:0] fmask = '0;
    logic [15:0] m_cand = '0;
    int          steps = 0;
    logic [1:0]  sd_pipe = '0;
    logic        sd = 1'b0;
    logic        fail_c;

    always @(posedge clk) begin
        if (sel_load) m_cand <= cand_idx;
        if (lfsr_res) steps <= 0;
        else if (lfsr_ena && steps < 1000) steps <= steps + 1;
        sd_pipe <= {sd_pipe[0], sel_load};
        sd <= sel_load ? 1'b0 : (sd | sd_pipe[1]);
    end

    assign sel_done     = sd;
    assign fail_c       = fmask[m_cand[3:0]];
    assign lfsr_failure = !mute && ((fail_c && steps >= 5) || (both && steps >= 15));
    assign lfsr_found   = !mute && (!fail_c || both) && steps >= 15;

    // Observation at the falling edge.
    int          loads = 0;
    int          dones = 0;
    int          cur_run = 0;
    logic [15:0] visited[$];
    logic [15:0] hits[$];
    int          runs[$];

    always @(negedge clk) begin
        if (sel_load) begin
            loads++;
            visited.push_back(cand_idx);
        end
        if (hit_bus.hit_valid && hit_bus.hit_ready) hits.push_back(hit_bus.hit_idx);
        if (done) dones++;
        if (lfsr_ena) cur_run++;
        else if (cur_run > 0) begin
            runs.push_back(cur_run);
            cur_run = 0;
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_obs();
        loads = 0;
        dones = 0;
        visited.delete();
        hits.delete();
        runs.delete();
    endtask

    task automatic launch(input logic [15:0] f, input logic [15:0] l);
        @(posedge clk);
        #1;
        clear_obs();
        cand_first = f;
        cand_last  = l;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (dones == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(dones > 0), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0]       first;
        logic [15:0]       last;
        logic [15:0]       fmask;
        bit                mute;
        bit                both;
        int                loads;
        int                hc;
        int                tmo;
        int                nh;
        logic [3:0][15:0]  h;
        int                run;
    } vec_t;

    vec_t vt[6];

    initial begin
        bit ok;
        int n;
        int d0;

        vt[0] = '{16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 1,
                  {16'h0, 16'h0, 16'h0, 16'h0000}, 16};
        vt[1] = '{16'h0003, 16'h0006, 16'h0050, 0, 0, 4, 2, 0, 2,
                  {16'h0, 16'h0, 16'h0005, 16'h0003}, 0};
        vt[2] = '{16'hFFFE, 16'h0001, 16'h0000, 0, 0, 4, 4, 0, 4,
                  {16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE}, 16};
        vt[3] = '{16'h0007, 16'h0008, 16'h0000, 1, 0, 2, 0, 2, 0,
                  {16'h0, 16'h0, 16'h0, 16'h0}, TMO};
        vt[4] = '{16'h0009, 16'h000A, 16'h0600, 0, 0, 2, 0, 0, 0,
                  {16'h0, 16'h0, 16'h0, 16'h0}, 6};
        vt[5] = '{16'h0002, 16'h0002, 16'h0000, 0, 1, 1, 0, 0, 0,
                  {16'h0, 16'h0, 16'h0, 16'h0}, 16};

        hit_bus.hit_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 32'({sel_load, lfsr_res, lfsr_ena, busy, done,
                             hit_bus.hit_valid}), 32'd0);
        chk("rst_regs", 32'(hit_count | tmo_count | cand_idx | hit_bus.hit_idx), 32'd0);
        @(posedge clk);
        #1;
        res = 1'b1;

        for (int i = 0; i < 6; i++) begin
            mute  = vt[i].mute;
            both  = vt[i].both;
            fmask = vt[i].fmask;
            launch(vt[i].first, vt[i].last);
            wait_done();
            chk($sformatf("v%0d_loads", i), 32'(loads), 32'(vt[i].loads));
            chk($sformatf("v%0d_hit_count", i), 32'(hit_count), 32'(vt[i].hc));
            chk($sformatf("v%0d_tmo_count", i), 32'(tmo_count), 32'(vt[i].tmo));
            chk($sformatf("v%0d_nhits", i), 32'(hits.size()), 32'(vt[i].nh));
            for (int k = 0; k < hits.size() && k < 4; k++)
                chk($sformatf("v%0d_hit%0d", i, k), 32'(hits[k]), 32'(vt[i].h[k]));
            ok = (visited.size() == vt[i].loads);
            for (int k = 0; k < visited.size(); k++)
                if (visited[k] != vt[i].first + 16'(k)) ok = 1'b0;
            chk($sformatf("v%0d_visit_order", i), 32'(ok), 32'd1);
            chk($sformatf("v%0d_done_once", i), 32'(dones), 32'd1);
            chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
            if (vt[i].run != 0) begin
                ok = (runs.size() == vt[i].loads);
                foreach (runs[k]) if (runs[k] != vt[i].run) ok = 1'b0;
                chk($sformatf("v%0d_run_len", i), 32'(ok), 32'd1);
            end
        end
        mute = 1'b0;
        both = 1'b0;
        fmask = '0;

        // Result stalled for 10 cycles.
        hit_bus.hit_ready = 1'b0;
        launch(16'h0000, 16'h0000);
        n = 0;
        while (!hit_bus.hit_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid_seen", 32'(hit_bus.hit_valid), 32'd1);
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!hit_bus.hit_valid || hit_bus.hit_idx != 16'h0 || lfsr_ena) ok = 1'b0;
            @(negedge clk);
        end
        chk("stall_hold", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        hit_bus.hit_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stall_accept_drop", 32'({hit_bus.hit_valid, lfsr_ena}), 32'd0);
        @(negedge clk);
        chk("stall_done_after_next", 32'(done), 32'd1);
        chk("stall_nhits", 32'(hits.size()), 32'd1);

        // Abort during the second candidate's RUN, after one timeout.
        mute = 1'b1;
        launch(16'h0000, 16'h0003);
        n = 0;
        while (tmo_count != 16'd1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_first_tmo", 32'(tmo_count), 32'd1);
        n = 0;
        while (!lfsr_ena && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        cand_first = 16'h0009;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'({busy, lfsr_ena, hit_bus.hit_valid, sel_load}), 32'd0);
        d0 = dones;
        repeat (5) @(negedge clk);
        chk("abort_no_done", 32'(dones), 32'(d0));
        chk("abort_tmo_hold", 32'(tmo_count), 32'd1);
        chk("abort_cand_hold", 32'(cand_idx), 32'd1);
        mute = 1'b0;

        // Asynchronous reset while a hit waits in REPORT.
        hit_bus.hit_ready = 1'b0;
        launch(16'h0005, 16'h0005);
        n = 0;
        while (!hit_bus.hit_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rep_valid_seen", 32'(hit_bus.hit_valid), 32'd1);
        d0 = dones;
        #2;
        res = 1'b0;
        #1;
        chk("async_rst_ctrl", 32'({sel_load, lfsr_res, lfsr_ena, busy, done,
                                   hit_bus.hit_valid}), 32'd0);
        chk("async_rst_regs", 32'(hit_count | tmo_count | cand_idx | hit_bus.hit_idx), 32'd0);
        @(posedge clk);
        #1;
        res = 1'b1;
        hit_bus.hit_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("async_rst_no_done", 32'(dones), 32'(d0));
        chk("async_rst_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/nlfsr_search_ctrl.md
# nlfsr_search_ctrl

Sequencer for the exhaustive NLFSR feedback search. It walks a range of candidate feedback-function indices, loads each into the feedback selector, resets and enables the NLFSR, and waits for its `found`/`failure` verdict or a watchdog timeout. Full-period candidates go out on a valid/ready result port. It sits between the host/top-level control and the selector + NLFSR pair, and is the only driver of the NLFSR `res`/`ena` inputs.

## Interface
- `SIZE`, 16: NLFSR width; period under test is 2^SIZE-1.
- `CAND_W`, 16: candidate index width.
- `TIMEOUT`, 2^SIZE+8: watchdog limit, in RUN cycles.
- `clk` in 1: single clock, rising edge.
- `res` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a search; sampled only in IDLE.
- `abort` in 1: terminate the search; return to IDLE.
- `cand_first` in CAND_W: first candidate index, captured at start.
- `cand_last` in CAND_W: last candidate index, captured at start.
- `sel_load` out 1: one-cycle pulse; selector loads `cand_idx`.
- `cand_idx` out CAND_W: current candidate.
- `sel_done` in 1: selector configured; level.
- `lfsr_res` out 1: synchronous active-high reset to the NLFSR.
- `lfsr_ena` out 1: NLFSR step enable.
- `lfsr_found` in 1: NLFSR full-period verdict.
- `lfsr_failure` in 1: NLFSR short-cycle verdict.
- `hit_valid` out 1: result valid.
- `hit_idx` out CAND_W: full-period candidate index.
- `hit_ready` in 1: consumer accepts the result.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the range is complete.
- `hit_count` out CAND_W: hits this search; saturates at all-ones.
- `tmo_count` out CAND_W: watchdog expiries this search; saturates at all-ones.

## Operation
- All outputs are registered. Async reset clears every output and counter to 0 and puts the FSM in IDLE.
- IDLE: on `start`, capture `cand_first`/`cand_last`, set `cand_idx`<=`cand_first`, clear `hit_count`/`tmo_count`, go to CLR.
- CLR (1 cycle): `lfsr_res`=1 and `sel_load`=1; `lfsr_ena`=0. Go to WAIT_SEL.
- WAIT_SEL: hold until `sel_done`=1, then clear the watchdog and go to RUN. `sel_done` sampled in the CLR cycle is ignored.
- RUN: `lfsr_ena`=1; the watchdog increments each cycle. Exits, in priority order:
  - `lfsr_failure` -> NEXT.
  - watchdog == TIMEOUT-1 -> `tmo_count`++ and go to NEXT.
  - `lfsr_found` -> increment `hit_count`, load `hit_idx`<=`cand_idx`, go to REPORT.
  - If `found` and `failure` are both high, failure wins.
- REPORT: `hit_valid`=1 and `lfsr_ena`=0. On `hit_valid && hit_ready`, drop `hit_valid` and go to NEXT. `hit_valid` never drops without `hit_ready`, except on abort or reset.
- NEXT (1 cycle):
  - If `cand_idx`==`cand_last`, go to DONE.
  - Otherwise `cand_idx`<=`cand_idx`+1 (mod 2^CAND_W, so `cand_last` < `cand_first` wraps through all-ones to 0) and go to CLR.
  - `cand_first`==`cand_last` tests exactly one candidate.
- DONE (1 cycle): `done`=1, then IDLE. Counters hold until the next `start`.
- `abort` in any non-IDLE state: the next state is IDLE, `lfsr_ena`/`hit_valid`/`sel_load` go to 0, `done` is not pulsed, and counters hold.
- `start` while busy is ignored.

## Timing
- `start` to `sel_load`/`lfsr_res` high: 1 cycle.
- `sel_done` high in WAIT_SEL to `lfsr_ena` high: 1 cycle.
- A verdict on cycle t drops `lfsr_ena` at t+1. One extra NLFSR step after the verdict is harmless because the NLFSR freezes on found/failure.
- Minimum per-candidate overhead outside RUN: CLR + WAIT_SEL(≥1) + NEXT = 3 cycles.
- Hit handshake: transfer on the rising edge where `hit_valid && hit_ready`. `hit_ready` may be held high constantly, giving a 1-cycle REPORT.
- The watchdog is SIZE+2 bits wide and is cleared on every entry to RUN.

## Structure
- Shared package `nlfsr_pkg`:
  - FSM state encoding: IDLE, CLR, WAIT_SEL, RUN, REPORT, NEXT, DONE.
  - Default TIMEOUT expression.
  - Saturating-increment function, shared with other search counters.
- One natural sub-module: `nlfsr_watchdog`, a clearable, enabled, saturating counter with a terminal-count output. Everything else is a single FSM process.

## Test plan
- SIZE=4, range 0..0, NLFSR model reports found after 15 steps, `hit_ready`=1 -> one `hit_valid` with `hit_idx`=0, `hit_count`=1, `done` pulse, `busy`=0 afterwards.
- Range 3..6, model fails candidates 4 and 6 -> hits 3 and 5 in order, `hit_count`=2, `tmo_count`=0, four `sel_load` pulses.
- Model never responds, SIZE=4 -> RUN lasts exactly 24 cycles per candidate, `tmo_count` increments, search continues to the next candidate.
- Found with `hit_ready`=0 for 10 cycles -> `hit_valid` held stable for 10 cycles, `hit_idx` stable, `lfsr_ena`=0 throughout, NEXT entered after acceptance.
- Range 0xFFFE..0x0001 -> candidates FFFE, FFFF, 0000, 0001 visited, then `done`.
- `abort` mid-RUN, and async `res` low mid-REPORT -> IDLE next cycle with no `done`. For the reset case, all outputs are 0 immediately, without waiting for a clock edge.
